forward_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage pipelined CPU. It tracks the destination register, write-enable and load flag of every in-flight instruction through ID/EX, EX/MEM and MEM/WB in its own shadow registers. From these it drives the 2-bit select inputs of the two ALU-operand 4-to-1 muxes in EX, and raises the load-use stall. It produces the select codes those muxes consume.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/forward_ctrl_fwd_sel.sv | 26 ++
 rtl/forward_ctrl.sv | 106 ++++++++++
 tb/tb_forward_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline hazard logic.
//   REG_AW      register-address width
//   fwd_sel_t   select code for the EX operand muxes
//   hz_stage_t  per-stage hazard record {rs1, rs2, rd, regwrite, memread}
//   HZ_BUBBLE   record value of an empty stage
package cpu_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } hz_stage_t;

   localparam hz_stage_t HZ_BUBBLE = '0;

   // True when a stage will write a register that a reader can pick up.
   // x0 is hard-wired to zero, so a write to it never produces a value.
   function automatic logic hz_writes(input hz_stage_t stg, input logic [REG_AW-1:0] src);
      return stg.regwrite && (stg.rd != '0) && (stg.rd == src);
   endfunction

endpackage

// File: rtl/forward_ctrl_fwd_sel.sv
// Operand forwarding select for one EX-stage ALU operand.
// Pure combinational priority compare: the younger producer (EX/MEM) wins
// over the older one (MEM/WB); with no producer the register file is used.
//   ex_mem  in  hazard record of the EX/MEM stage
//   mem_wb  in  hazard record of the MEM/WB stage
//   src     in  source register of the instruction in EX
//   sel     out mux select (FWD_MEM / FWD_WB / FWD_RF)
module fwd_sel
   import cpu_pkg::*;
(
   input  hz_stage_t         ex_mem,
   input  hz_stage_t         mem_wb,
   input  logic [REG_AW-1:0] src,
   output fwd_sel_t          sel
);

   always_comb begin
      sel = FWD_RF;
      if (hz_writes(ex_mem, src)) begin
         sel = FWD_MEM;
      end else if (hz_writes(mem_wb, src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps shadow copies of the hazard-relevant fields of the instructions in
// ID/EX, EX/MEM and MEM/WB, drives the two EX operand-mux selects from them
// and raises the load-use stall.
//   clk_i          in  clock, rising edge
//   rst_i          in  synchronous active-high reset
//   id_valid_i     in  ID stage holds a real instruction
//   id_rs1_i       in  rs1 of the ID instruction
//   id_rs2_i       in  rs2 of the ID instruction
//   id_rd_i        in  rd of the ID instruction
//   id_regwrite_i  in  ID instruction writes rd
//   id_memread_i   in  ID instruction is a load
//   flush_i        in  branch taken, squash the ID instruction
//   forward_a_o    out operand-A select (00 RF, 10 EX/MEM, 01 MEM/WB)
//   forward_b_o    out operand-B select
//   stall_o        out hold PC and IF/ID, bubble ID/EX
//   stall_cnt_o    out saturating count of stall cycles since reset
// The register file is expected to write-through same-cycle WB/ID traffic;
// there is no ID-stage bypass here.
module forward_ctrl #(
   parameter int REG_AW = cpu_pkg::REG_AW,  // must match the package width
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   output logic [1:0]        forward_a_o,
   output logic [1:0]        forward_b_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   import cpu_pkg::hz_stage_t;
   import cpu_pkg::fwd_sel_t;
   import cpu_pkg::HZ_BUBBLE;

   hz_stage_t id_ex;
   hz_stage_t ex_mem;
   hz_stage_t mem_wb;
   hz_stage_t id_stage;

   fwd_sel_t  sel_a;
   fwd_sel_t  sel_b;

   logic      load_use;
   logic      bubble;

   always_comb begin
      id_stage          = HZ_BUBBLE;
      id_stage.rs1      = id_rs1_i;
      id_stage.rs2      = id_rs2_i;
      id_stage.rd       = id_rd_i;
      id_stage.regwrite = id_regwrite_i;
      id_stage.memread  = id_memread_i;
   end

   // rs2 is compared even for instructions that ignore it; the occasional
   // false stall costs one cycle and keeps the decode-free compare simple.
   assign load_use = id_valid_i && id_ex.memread && (id_ex.rd != '0) &&
                     ((id_ex.rd == id_rs1_i) || (id_ex.rd == id_rs2_i));

   // A taken branch squashes the dependent instruction anyway, so the stall
   // is dropped to let IF redirect in the same cycle.
   assign stall_o = load_use && !flush_i;
   assign bubble  = stall_o || flush_i || !id_valid_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_ex       <= HZ_BUBBLE;
         ex_mem      <= HZ_BUBBLE;
         mem_wb      <= HZ_BUBBLE;
         stall_cnt_o <= '0;
      end else begin
         id_ex  <= bubble ? HZ_BUBBLE : id_stage;
         ex_mem <= id_ex;
         mem_wb <= ex_mem;
         if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
         end
      end
   end

   fwd_sel u_fwd_a (
      .ex_mem (ex_mem),
      .mem_wb (mem_wb),
      .src    (id_ex.rs1),
      .sel    (sel_a)
   );

   fwd_sel u_fwd_b (
      .ex_mem (ex_mem),
      .mem_wb (mem_wb),
      .src    (id_ex.rs2),
      .sel    (sel_b)
   );

   assign forward_a_o = sel_a;
   assign forward_b_o = sel_b;

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       id_valid_i;
   logic [4:0] id_rs1_i;
   logic [4:0] id_rs2_i;
   logic [4:0] id_rd_i;
   logic       id_regwrite_i;
   logic       id_memread_i;
   logic       flush_i;

   logic [1:0]  fa, fb, fa3, fb3;
   logic        st, st3;
   logic [31:0] cnt;
   logic [2:0]  cnt3;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   forward_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .flush_i(flush_i), .forward_a_o(fa), .forward_b_o(fb),
      .stall_o(st), .stall_cnt_o(cnt)
   );

   forward_ctrl #(.CNT_W(3)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .flush_i(flush_i), .forward_a_o(fa3), .forward_b_o(fb3),
      .stall_o(st3), .stall_cnt_o(cnt3)
   );

   // ---------------- reference model ----------------
   // hist[1] is the instruction in EX, hist[2] the one issued a cycle before
   // it, hist[3] two cycles before. A consumer takes its operand from the
   // most recently issued producer of that register.
   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       rw, mr;
   } ins_t;

   ins_t        hist [1:3];
   longint      m_stalls;

   function automatic ins_t nop_ins();
      ins_t n;
      n.rs1 = 0; n.rs2 = 0; n.rd = 0; n.rw = 0; n.mr = 0;
      return n;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs == 0) return 2'b00;
      for (int d = 2; d <= 3; d++)
         if (hist[d].rw && hist[d].rd == rs)
            return (d == 2) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_stall();
      return id_valid_i && !flush_i && hist[1].mr && hist[1].rd != 0 &&
             (hist[1].rd == id_rs1_i || hist[1].rd == id_rs2_i);
   endfunction

   function automatic longint m_cnt(input int w);
      longint lim = (64'd1 << w) - 1;
      return (m_stalls > lim) ? lim : m_stalls;
   endfunction

   task automatic model_step();
      ins_t cur;
      logic s = m_stall();
      if (rst_i) begin
         for (int k = 1; k <= 3; k++) hist[k] = nop_ins();
         m_stalls = 0;
      end else begin
         cur.rs1 = id_rs1_i; cur.rs2 = id_rs2_i; cur.rd = id_rd_i;
         cur.rw = id_regwrite_i; cur.mr = id_memread_i;
         hist[3] = hist[2];
         hist[2] = hist[1];
         hist[1] = (id_valid_i && !flush_i && !s) ? cur : nop_ins();
         if (s) m_stalls++;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl, input logic rs);
      @(negedge clk_i);
      id_valid_i = v; id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
      id_regwrite_i = rw; id_memread_i = mr; flush_i = fl; rst_i = rs;
      #1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic       v;
      logic [4:0] rs1, rs2, rd;
      logic       rw, mr, fl, rst;
      logic [1:0] fa, fb;
      logic       st;
      int         cnt;
   } vec_t;

   vec_t tbl [27];

   initial begin
      // add x5; sub x6,x5,x7 -> MEM forward on A
      tbl[0]  = '{1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[1]  = '{1, 5, 7, 6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0};
      // add x5; nop; or x8,x5,x5 -> WB forward on both
      tbl[3]  = '{1, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[5]  = '{1, 5, 5, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0};
      // two writers of x5 back to back -> EX/MEM wins
      tbl[7]  = '{1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[8]  = '{1, 3, 4, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[9]  = '{1, 5, 5, 9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0};
      // writer of x0 followed by a reader of x0
      tbl[11] = '{1, 1, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[12] = '{1, 0, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      // lw x9; add x10,x9,x1 -> one stall, then load result from MEM/WB
      tbl[15] = '{1, 2, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[16] = '{1, 9, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0};
      tbl[17] = '{1, 9, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1};
      tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1};
      // load-use with flush in the same cycle
      tbl[19] = '{1, 2, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1};
      tbl[20] = '{1, 9, 9, 10, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1};
      tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1};
      tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1};
      // reset during a stall
      tbl[23] = '{1, 2, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1};
      tbl[24] = '{1, 9, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1};
      tbl[25] = '{1, 9, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0};
      tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int k = 1; k <= 3; k++) hist[k] = nop_ins();
      m_stalls = 0;

      repeat (2) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1);
         @(posedge clk_i); model_step();
      end

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
               tbl[i].rw, tbl[i].mr, tbl[i].fl, tbl[i].rst);
         chk($sformatf("vec%0d fwd_a", i), fa, tbl[i].fa);
         chk($sformatf("vec%0d fwd_b", i), fb, tbl[i].fb);
         chk($sformatf("vec%0d stall", i), st, tbl[i].st);
         chk($sformatf("vec%0d cnt", i), cnt, tbl[i].cnt);
         chk($sformatf("vec%0d cnt3", i), cnt3, (tbl[i].cnt > 7) ? 7 : tbl[i].cnt);
         @(posedge clk_i); model_step();
      end

      // Repeated lw x9,0(x9): every second cycle is a load-use stall.
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk_i); model_step();
      for (int i = 0; i < 20; i++) begin
         drive(1, 9, 0, 9, 1, 1, 0, 0);
         chk($sformatf("sat%0d stall", i), st, (i % 2) == 1);
         chk($sformatf("sat%0d cnt3", i), cnt3, (i / 2 > 7) ? 7 : i / 2);
         @(posedge clk_i); model_step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("sat end cnt", cnt, 10);
      chk("sat end cnt3", cnt3, 7);
      @(posedge clk_i); model_step();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
               $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
         chk("rnd fwd_a", fa, m_fwd(hist[1].rs1));
         chk("rnd fwd_b", fb, m_fwd(hist[1].rs2));
         chk("rnd stall", st, m_stall());
         chk("rnd cnt", cnt, m_cnt(32));
         chk("rnd cnt3", cnt3, m_cnt(3));
         @(posedge clk_i); model_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
